// File: rtl/ct_spsram_pkg.sv
// Shared types and elaboration helpers for the parametrised single-port SRAM
// wrapper with a taint shadow array.
package ct_spsram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } spsram_state_e;

    function automatic int spsram_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic bit rd_latency_ok(input int rd_latency);
        return (rd_latency == 1) || (rd_latency == 2);
    endfunction

endpackage

// File: rtl/ct_spsram_bitmask_array.sv
// Generic single-port DEPTH x DATA_WIDTH array with a per-bit active-high write
// enable and a registered read address (write-first, read data is combinational).
module ct_spsram_bitmask_array
    import ct_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  we,
    input  logic                  hold_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] bit_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = spsram_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] raddr_q;

    always_ff @(posedge CLK) begin
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (we && bit_we[i]) begin
                mem[addr][i] <= wdata[i];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            raddr_q <= '0;
        end else if (hold_en) begin
            raddr_q <= addr;
        end
    end

    // Reading through the registered address after the write edge makes a
    // write access return the merged word on the following cycle.
    assign rdata = mem[raddr_q];

endmodule

// File: rtl/ct_spsram_shadow_param.sv
// Parametrised single-port SRAM wrapper: per-bit write mask, 1/2-cycle read
// latency, post-reset clear sweep and cell-level taint shadow array.
module ct_spsram_shadow_param
    import ct_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 128,
    parameter int RD_LATENCY    = 1,
    parameter bit INIT_ON_RESET = 1'b1,
    parameter bit TAINT_EN      = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [ADDR_WIDTH-1:0] A_t0,
    input  logic                  CEN,
    input  logic                  CEN_t0,
    input  logic                  GWEN,
    input  logic                  GWEN_t0,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] WEN_t0,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] D_t0,
    output logic [DATA_WIDTH-1:0] Q,
    output logic [DATA_WIDTH-1:0] Q_t0,
    output logic                  INIT_BUSY
);

    localparam int DEPTH = spsram_depth(ADDR_WIDTH);
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_rd_latency
        $error("ct_spsram_shadow_param: RD_LATENCY must be 1 or 2");
    end

    spsram_state_e    state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= INIT_ON_RESET ? ST_INIT : ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_INIT: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST_CNT) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    logic in_init, access, data_wr;
    assign in_init   = (state == ST_INIT);
    assign INIT_BUSY = in_init;
    assign access    = !in_init && !CEN;
    assign data_wr   = access && !GWEN;

    logic [ADDR_WIDTH-1:0] arr_addr;
    assign arr_addr = in_init ? cnt[ADDR_WIDTH-1:0] : A;

    // Until the first host access the read address points at nothing valid.
    logic rd_vld;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_vld <= 1'b0;
        end else if (access) begin
            rd_vld <= 1'b1;
        end
    end

    logic [DATA_WIDTH-1:0] data_rd, q_s1, qt_s1;

    ct_spsram_bitmask_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_data (
        .CLK    (CLK),
        .RST    (RST),
        .we     (in_init || data_wr),
        .hold_en(access),
        .addr   (arr_addr),
        .bit_we (in_init ? {DATA_WIDTH{1'b1}} : ~WEN),
        .wdata  (in_init ? {DATA_WIDTH{1'b0}} : D),
        .rdata  (data_rd)
    );

    assign q_s1 = rd_vld ? data_rd : '0;

    if (TAINT_EN) begin : g_taint
        logic                  ctl_t, sh_wr, addr_hold_t0;
        logic [DATA_WIDTH-1:0] written, taint_or, sh_bwe, sh_wdata, sh_rd;

        assign ctl_t    = GWEN_t0 || CEN_t0 || (|A_t0);
        assign sh_wr    = access && (!GWEN || GWEN_t0);
        assign written  = {DATA_WIDTH{!GWEN}} & ~WEN;
        assign taint_or = WEN_t0 | {DATA_WIDTH{ctl_t}};
        // Unwritten bits only ever gain taint, so they are written with 1
        // exactly where taint_or is set and left alone elsewhere.
        assign sh_bwe   = written | taint_or;
        assign sh_wdata = (written & (D_t0 | taint_or)) | ~written;

        ct_spsram_bitmask_array #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_shadow (
            .CLK    (CLK),
            .RST    (RST),
            .we     (in_init || sh_wr),
            .hold_en(access),
            .addr   (arr_addr),
            .bit_we (in_init ? {DATA_WIDTH{1'b1}} : sh_bwe),
            .wdata  (in_init ? {DATA_WIDTH{1'b0}} : sh_wdata),
            .rdata  (sh_rd)
        );

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                addr_hold_t0 <= 1'b0;
            end else if (!in_init) begin
                if (!CEN) begin
                    addr_hold_t0 <= (|A_t0) || CEN_t0;
                end else if (CEN_t0) begin
                    addr_hold_t0 <= 1'b1;
                end
            end
        end

        assign qt_s1 = (rd_vld ? sh_rd : '0) | {DATA_WIDTH{addr_hold_t0}};
    end else begin : g_no_taint
        assign qt_s1 = '0;
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] q_s2, qt_s2;
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                q_s2  <= '0;
                qt_s2 <= '0;
            end else begin
                q_s2  <= q_s1;
                qt_s2 <= qt_s1;
            end
        end
        assign Q    = q_s2;
        assign Q_t0 = qt_s2;
    end else begin : g_lat1
        assign Q    = q_s1;
        assign Q_t0 = qt_s1;
    end

endmodule
